// File: rtl/l15_l2_req_arbiter_pkg.sv
// Shared widths, message encodings and FSM state encoding for the L1.5->L2 request arbiter.
package l15_l2_req_arbiter_pkg;

  localparam int unsigned MsgWidth  = 8;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned TagWidth  = 8;

  localparam logic [MsgWidth-1:0] MsgTypeEmpty = '0;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  typedef enum logic {
    StEmpty = ST_EMPTY,
    StFull  = ST_FULL
  } arb_state_e;

endpackage

// File: rtl/l15_l2_req_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after the pointer, as one-hot and index.
module l15_l2_req_arbiter_rr_pick #(
  parameter int unsigned NumCores = 4,
  parameter int unsigned SrcBits  = 2
) (
  input  logic [SrcBits-1:0]  ptr_i,
  input  logic [NumCores-1:0] valid_i,
  output logic [NumCores-1:0] gnt_o,
  output logic [SrcBits-1:0]  idx_o,
  output logic                any_o
);

  logic [SrcBits-1:0] cand;

  always_comb begin
    cand  = '0;
    idx_o = '0;
    gnt_o = '0;
    any_o = |valid_i;
    // Scan farthest-first so the closest candidate to the pointer is assigned last and wins.
    for (int k = NumCores - 1; k >= 0; k--) begin
      cand = ptr_i + SrcBits'(k);
      if (valid_i[cand]) begin
        idx_o = cand;
      end
    end
    if (any_o) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/l15_l2_req_arbiter.sv
// Shares one L1.5->L2 message channel: memory source has absolute priority, cores are
// served round-robin, and each grant sits in a one-entry output register until accepted.
module l15_l2_req_arbiter
  import l15_l2_req_arbiter_pkg::*;
#(
  parameter int unsigned NumCores = 4,
  parameter int unsigned SrcBits  = 2,
  parameter int unsigned MsgW     = MsgWidth,
  parameter int unsigned DataW    = DataWidth,
  parameter int unsigned TagW     = TagWidth
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumCores-1:0]       core_valid_i,
  input  logic [NumCores*MsgW-1:0]  core_type_i,
  input  logic [NumCores*DataW-1:0] core_data_i,
  input  logic [NumCores*TagW-1:0]  core_tag_i,
  output logic [NumCores-1:0]       core_ready_o,
  input  logic                      mem_valid_i,
  input  logic [MsgW-1:0]           mem_type_i,
  input  logic [DataW-1:0]          mem_data_i,
  input  logic [TagW-1:0]           mem_tag_i,
  output logic                      mem_ready_o,
  output logic                      out_valid_o,
  output logic [MsgW-1:0]           out_type_o,
  output logic [DataW-1:0]          out_data_o,
  output logic [TagW-1:0]           out_tag_o,
  output logic [SrcBits-1:0]        out_source_o,
  output logic                      out_is_mem_o,
  input  logic                      out_ready_i
);

  arb_state_e          state_q, state_d;
  logic [SrcBits-1:0]  ptr_q, ptr_d;
  logic [MsgW-1:0]     type_q, type_d;
  logic [DataW-1:0]    data_q, data_d;
  logic [TagW-1:0]     tag_q, tag_d;
  logic [SrcBits-1:0]  src_q, src_d;
  logic                is_mem_q, is_mem_d;

  logic [NumCores-1:0] pick_gnt;
  logic [SrcBits-1:0]  pick_idx;
  logic                pick_any;
  logic                load_en;
  int unsigned         sel;

  l15_l2_req_arbiter_rr_pick #(
    .NumCores (NumCores),
    .SrcBits  (SrcBits)
  ) u_rr_pick (
    .ptr_i   (ptr_q),
    .valid_i (core_valid_i),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    type_d       = type_q;
    data_d       = data_q;
    tag_d        = tag_q;
    src_d        = src_q;
    is_mem_d     = is_mem_q;
    core_ready_o = '0;
    mem_ready_o  = 1'b0;
    sel          = 32'(pick_idx);
    load_en      = (state_q == StEmpty) || out_ready_i;

    // Readies are suppressed in the reset cycle so no request is consumed and then dropped.
    if (!rst_i && load_en) begin
      if (mem_valid_i) begin
        mem_ready_o = 1'b1;
        state_d     = StFull;
        type_d      = mem_type_i;
        data_d      = mem_data_i;
        tag_d       = mem_tag_i;
        src_d       = '0;
        is_mem_d    = 1'b1;
      end else if (pick_any) begin
        core_ready_o = pick_gnt;
        state_d      = StFull;
        type_d       = core_type_i[sel*MsgW +: MsgW];
        data_d       = core_data_i[sel*DataW +: DataW];
        tag_d        = core_tag_i[sel*TagW +: TagW];
        src_d        = pick_idx;
        is_mem_d     = 1'b0;
        ptr_d        = pick_idx + SrcBits'(1);
      end else if (state_q == StFull) begin
        state_d = StEmpty;
        type_d  = MsgTypeEmpty;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StEmpty;
      ptr_q    <= '0;
      type_q   <= MsgTypeEmpty;
      data_q   <= '0;
      tag_q    <= '0;
      src_q    <= '0;
      is_mem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      type_q   <= type_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
      src_q    <= src_d;
      is_mem_q <= is_mem_d;
    end
  end

  assign out_valid_o  = (state_q == StFull);
  assign out_type_o   = type_q;
  assign out_data_o   = data_q;
  assign out_tag_o    = tag_q;
  assign out_source_o = src_q;
  assign out_is_mem_o = is_mem_q;

endmodule
